// File: rtl/decode_pkg.sv
// Shared types for the decode stage: control word layout, opcode and immediate-select encodings.
package decode_pkg;

    typedef struct packed {
        logic       pc_src;
        logic       reg_write;
        logic       mem_write;
        logic       mem_reg;
        logic       alu_src;
        logic       no_write;
        logic       mov_src;
        logic       flag_write;
        logic       branch_taken;
        logic [1:0] alu_ctrl;
        logic [1:0] imm_src;
    } ctrl_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [1:0] IMM_ZX7  = 2'b00;
    localparam logic [1:0] IMM_ZX11 = 2'b01;
    localparam logic [1:0] IMM_SX19 = 2'b10;

endpackage

// File: rtl/decode_ctrl_lut.sv
// Combinational op/funct -> control word lookup.
module decode_ctrl_lut
    import decode_pkg::*;
(
    input  logic [1:0] op,
    input  logic [3:0] funct,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (op)
            OP_DP: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_ctrl   = funct[2:1];
                ctrl.flag_write = funct[0];
                ctrl.alu_src    = funct[3];
                ctrl.imm_src    = IMM_ZX7;
            end
            OP_MEM: begin
                ctrl.alu_src = 1'b1;
                ctrl.imm_src = IMM_ZX11;
                if (funct[0]) begin
                    ctrl.mem_reg   = 1'b1;
                    ctrl.reg_write = 1'b1;
                end else begin
                    ctrl.mem_write = 1'b1;
                end
            end
            OP_BR: begin
                ctrl.pc_src       = 1'b1;
                ctrl.branch_taken = 1'b1;
                ctrl.reg_write    = funct[0];
                ctrl.imm_src      = IMM_SX19;
            end
            default: ctrl.no_write = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage with register file and ID/EX register. Define DECODE_WB_BYPASS_EN to forward
// same-cycle write-back data into operands instead of stalling on the collision.
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter  int DATA_W   = 22,
    parameter  int REG_CNT  = 16,
    parameter  int LINK_REG = 11,
    localparam int REG_AW   = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [21:0]       instr,
    input  logic [DATA_W-1:0] pc_plus_8,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_rd1,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_imm,
    output logic [REG_AW-1:0] out_dst,
    output ctrl_t             out_ctrl
);

    localparam logic [REG_AW-1:0] LINK_A = REG_AW'(LINK_REG);

    logic [DATA_W-1:0] rf [REG_CNT];

    logic [1:0]        op;
    logic [3:0]        funct;
    logic [REG_AW-1:0] rn, rd, rm, src1, src2, dec_dst;
    logic [DATA_W-1:0] rd1_val, rd2_val, dec_rd1, dec_imm;
    logic              use1, use2, is_link, load_use, collide, hold;
    logic              unused_msb;
    ctrl_t             dec_ctrl;

    assign unused_msb = instr[21];
    assign op    = instr[20:19];
    assign funct = instr[18:15];
    assign rn    = instr[11 +: REG_AW];
    assign rd    = instr[7 +: REG_AW];
    assign rm    = instr[3 +: REG_AW];

    assign src1 = (op == OP_BR) ? LINK_A : rn;
    assign src2 = rm;

    // Which register fields the instruction actually consumes (drives hazard checks).
    assign use1 = (op == OP_DP) || (op == OP_MEM);
    assign use2 = ((op == OP_DP) && !funct[3]) || ((op == OP_MEM) && !funct[0]);

`ifdef DECODE_WB_BYPASS_EN
    assign rd1_val = (wb_we && (wb_addr == src1)) ? wb_data : rf[src1];
    assign rd2_val = (wb_we && (wb_addr == src2)) ? wb_data : rf[src2];
    assign collide = 1'b0;
`else
    assign rd1_val = rf[src1];
    assign rd2_val = rf[src2];
    assign collide = wb_we && ((use1 && (wb_addr == src1)) || (use2 && (wb_addr == src2)));
`endif

    decode_ctrl_lut u_lut (
        .op    (op),
        .funct (funct),
        .ctrl  (dec_ctrl)
    );

    assign is_link = (op == OP_BR) && funct[0];
    assign dec_rd1 = is_link ? pc_plus_8 : rd1_val;
    assign dec_dst = is_link ? LINK_A : rd;

    always_comb begin
        case (dec_ctrl.imm_src)
            IMM_ZX7:  dec_imm = DATA_W'(instr[6:0]);
            IMM_ZX11: dec_imm = DATA_W'(instr[10:0]);
            default:  dec_imm = DATA_W'($signed(instr[18:0]));
        endcase
    end

    assign hold     = out_valid && !out_ready;
    assign load_use = out_valid && out_ctrl.mem_reg &&
                      ((use1 && (out_dst == src1)) || (use2 && (out_dst == src2)));
    assign in_ready = !rst || (!hold && !load_use && !collide);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_CNT; i++) rf[i] <= '0;
        end else if (wb_we) begin
            rf[wb_addr] <= wb_data;
        end
    end

    // Flush beats hold; an empty slot always carries an all-zero control word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_rd1   <= '0;
            out_rd2   <= '0;
            out_imm   <= '0;
            out_dst   <= '0;
            out_ctrl  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (!hold) begin
            if (in_valid && in_ready) begin
                out_valid <= 1'b1;
                out_rd1   <= dec_rd1;
                out_rd2   <= rd2_val;
                out_imm   <= dec_imm;
                out_dst   <= dec_dst;
                out_ctrl  <= dec_ctrl;
            end else begin
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: vector table plus multi-cycle sequences.
module tb_decode_stage_pipe;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:0] instr = '0;
    logic [21:0] pc_plus_8 = '0;
    logic        wb_we = 1'b0;
    logic [3:0]  wb_addr = '0;
    logic [21:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [21:0] out_rd1, out_rd2, out_imm;
    logic [3:0]  out_dst;
    ctrl_t       out_ctrl;

    int checks = 0;
    int errors = 0;

    decode_stage_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc_plus_8 (pc_plus_8),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd1   (out_rd1),
        .out_rd2   (out_rd2),
        .out_imm   (out_imm),
        .out_dst   (out_dst),
        .out_ctrl  (out_ctrl)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  funct, rn, rd, rm;
        logic [2:0]  lo;
        logic [21:0] pc8, rd1, rd2, imm;
        logic [3:0]  dst;
        ctrl_t       ctrl;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] mk(input logic [1:0] op, input logic [3:0] f,
                                       input logic [3:0] rn, input logic [3:0] rd,
                                       input logic [3:0] rm, input logic [2:0] lo);
        return {1'b0, op, f, rn, rd, rm, lo};
    endfunction

    function automatic ctrl_t mkc(input bit pc, input bit rw, input bit mw, input bit mr,
                                  input bit as, input bit nw, input bit fw, input bit bt,
                                  input logic [1:0] alu, input logic [1:0] imm);
        ctrl_t c;
        c = '0;
        c.pc_src = pc; c.reg_write = rw; c.mem_write = mw; c.mem_reg = mr;
        c.alu_src = as; c.no_write = nw; c.flag_write = fw; c.branch_taken = bt;
        c.alu_ctrl = alu; c.imm_src = imm;
        return c;
    endfunction

    task automatic wb_write(input logic [3:0] a, input logic [21:0] d);
        wb_we = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_we = 1'b0;
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{op:2'b00, funct:4'b0010, rn:4'd1, rd:4'd6, rm:4'd2, lo:3'b000, pc8:22'h0,
                    rd1:22'h111, rd2:22'h222, imm:22'h10, dst:4'd6,
                    ctrl:mkc(0,1,0,0,0,0,0,0,2'b01,2'b00)};
        vecs[1] = '{op:2'b00, funct:4'b1111, rn:4'd2, rd:4'd3, rm:4'd15, lo:3'b101, pc8:22'h0,
                    rd1:22'h222, rd2:22'h0, imm:22'h7D, dst:4'd3,
                    ctrl:mkc(0,1,0,0,1,0,1,0,2'b11,2'b00)};
        vecs[2] = '{op:2'b01, funct:4'b0001, rn:4'd1, rd:4'd5, rm:4'd3, lo:3'b010, pc8:22'h0,
                    rd1:22'h111, rd2:22'hABC, imm:22'h29A, dst:4'd5,
                    ctrl:mkc(0,1,0,1,1,0,0,0,2'b00,2'b01)};
        vecs[3] = '{op:2'b01, funct:4'b0000, rn:4'd2, rd:4'd0, rm:4'd1, lo:3'b000, pc8:22'h0,
                    rd1:22'h222, rd2:22'h111, imm:22'h008, dst:4'd0,
                    ctrl:mkc(0,0,1,0,1,0,0,0,2'b00,2'b01)};
        vecs[4] = '{op:2'b10, funct:4'b1110, rn:4'd0, rd:4'd9, rm:4'd0, lo:3'b000, pc8:22'h40,
                    rd1:22'hB0B, rd2:22'h0, imm:22'h3F0480, dst:4'd9,
                    ctrl:mkc(1,0,0,0,0,0,0,1,2'b00,2'b10)};
        vecs[5] = '{op:2'b11, funct:4'b0000, rn:4'd1, rd:4'd2, rm:4'd3, lo:3'b001, pc8:22'h0,
                    rd1:22'h111, rd2:22'hABC, imm:22'h19, dst:4'd2,
                    ctrl:mkc(0,0,0,0,0,1,0,0,2'b00,2'b00)};

        // Reset state
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_rd1", 32'(out_rd1), 0);
        chk("rst_out_ctrl", 32'(out_ctrl), 0);
        rst = 1'b1;
        tick();

        wb_write(4'd1, 22'h111);
        wb_write(4'd2, 22'h222);
        wb_write(4'd11, 22'hB0B);

        // Write r3 then ADD r3,r3
        wb_write(4'd3, 22'h00ABC);
        in_valid = 1'b1; instr = mk(2'b00, 4'b0000, 4'd3, 4'd1, 4'd3, 3'b000);
        tick();
        in_valid = 1'b0;
        chk("add_out_valid", 32'(out_valid), 1);
        chk("add_rd1", 32'(out_rd1), 32'h00ABC);
        chk("add_rd2", 32'(out_rd2), 32'h00ABC);
        chk("add_reg_write", 32'(out_ctrl.reg_write), 1);
        drain();

        // Vector table, offered back to back
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            instr = mk(vecs[i].op, vecs[i].funct, vecs[i].rn, vecs[i].rd, vecs[i].rm, vecs[i].lo);
            pc_plus_8 = vecs[i].pc8;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
            chk($sformatf("v%0d_rd1", i), 32'(out_rd1), 32'(vecs[i].rd1));
            chk($sformatf("v%0d_rd2", i), 32'(out_rd2), 32'(vecs[i].rd2));
            chk($sformatf("v%0d_imm", i), 32'(out_imm), 32'(vecs[i].imm));
            chk($sformatf("v%0d_dst", i), 32'(out_dst), 32'(vecs[i].dst));
            chk($sformatf("v%0d_ctrl", i), 32'(out_ctrl), 32'(vecs[i].ctrl));
        end
        drain();

        // Load-use: LOAD r5 followed by consumer of r5
        in_valid = 1'b1; instr = mk(2'b01, 4'b0001, 4'd1, 4'd5, 4'd0, 3'b000);
        tick();
        instr = mk(2'b00, 4'b0000, 4'd5, 4'd6, 4'd2, 3'b000);
        #1;
        chk("lu_stall", 32'(in_ready), 0);
        chk("lu_load_in_ex", 32'(out_ctrl.mem_reg), 1);
        tick();
        chk("lu_bubble_valid", 32'(out_valid), 0);
        chk("lu_bubble_ctrl", 32'(out_ctrl), 0);
        chk("lu_ready_again", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("lu_cons_valid", 32'(out_valid), 1);
        chk("lu_cons_dst", 32'(out_dst), 6);
        chk("lu_cons_rd2", 32'(out_rd2), 32'h222);
        drain();

        // Hold under out_ready=0 for three cycles
        in_valid = 1'b1; instr = mk(2'b00, 4'b0000, 4'd1, 4'd4, 4'd2, 3'b000);
        tick();
        instr = mk(2'b00, 4'b0000, 4'd2, 4'd8, 4'd1, 3'b000);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("hold%0d_in_ready", k), 32'(in_ready), 0);
            chk($sformatf("hold%0d_valid", k), 32'(out_valid), 1);
            chk($sformatf("hold%0d_dst", k), 32'(out_dst), 4);
            chk($sformatf("hold%0d_rd1", k), 32'(out_rd1), 32'h111);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("hold_release_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("hold_next_dst", 32'(out_dst), 8);
        chk("hold_next_rd1", 32'(out_rd1), 32'h222);
        drain();

        // Branch-with-link then flush over a held slot
        in_valid = 1'b1; instr = mk(2'b10, 4'b0001, 4'd0, 4'd2, 4'd0, 3'b000);
        pc_plus_8 = 22'h100;
        tick();
        chk("bl_valid", 32'(out_valid), 1);
        chk("bl_dst", 32'(out_dst), 11);
        chk("bl_rd1", 32'(out_rd1), 32'h100);
        chk("bl_imm", 32'(out_imm), 32'h8100);
        chk("bl_ctrl", 32'(out_ctrl), 32'(mkc(1,1,0,0,0,0,0,1,2'b00,2'b10)));
        instr = mk(2'b00, 4'b0000, 4'd1, 4'd3, 4'd2, 3'b000);
        flush = 1'b1; out_ready = 1'b0;
        tick();
        flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 0);
        chk("flush_ctrl", 32'(out_ctrl), 0);
        tick();
        chk("flush_discard", 32'(out_valid), 0);

        // Write-back collision on r7
        wb_we = 1'b1; wb_addr = 4'd7; wb_data = 22'h55;
        in_valid = 1'b1; instr = mk(2'b00, 4'b0000, 4'd7, 4'd9, 4'd0, 3'b000);
        #1;
`ifdef DECODE_WB_BYPASS_EN
        chk("wb_bypass_ready", 32'(in_ready), 1);
        tick();
        wb_we = 1'b0; in_valid = 1'b0;
`else
        chk("wb_collide_stall", 32'(in_ready), 0);
        tick();
        wb_we = 1'b0;
        chk("wb_stall_bubble", 32'(out_valid), 0);
        #1;
        chk("wb_ready_after", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
`endif
        chk("wb_valid", 32'(out_valid), 1);
        chk("wb_rd1", 32'(out_rd1), 32'h55);

        // Reset during a transfer
        in_valid = 1'b1; instr = mk(2'b00, 4'b0000, 4'd1, 4'd10, 4'd3, 3'b000);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_rd1", 32'(out_rd1), 0);
        chk("rst_mid_dst", 32'(out_dst), 0);
        chk("rst_mid_ready", 32'(in_ready), 1);
        tick();
        chk("rst_hold_valid", 32'(out_valid), 0);
        rst = 1'b1;
        #1;
        chk("rst_rel_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("rst_first_valid", 32'(out_valid), 1);
        chk("rst_first_dst", 32'(out_dst), 10);
        chk("rst_first_rd1", 32'(out_rd1), 0);
        chk("rst_first_ctrl", 32'(out_ctrl), 32'(mkc(0,1,0,0,0,0,0,0,2'b00,2'b00)));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
